// File: rtl/dmem_port_if.sv
// Bundle of the three requester ports and the BRAM port around dmem_port_arbiter.
// slave = arbiter side, master = requesters plus the memory model.
interface dmem_port_if #(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 16
);
   logic              d_req, d_we, d_gnt, d_rvalid;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic              f_req, f_gnt, f_rvalid;
   logic [ADDR_W-1:0] f_addr;
   logic              x_req, x_we, x_gnt, x_rvalid;
   logic [ADDR_W-1:0] x_addr;
   logic [DATA_W-1:0] x_wdata;
   logic [DATA_W-1:0] rdata;
   logic              mem_en, mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_din, mem_dout;
   logic [3:0]        x_wait;

   modport slave (
      input  d_req, d_we, d_addr, d_wdata, f_req, f_addr,
             x_req, x_we, x_addr, x_wdata, mem_dout,
      output d_gnt, d_rvalid, f_gnt, f_rvalid, x_gnt, x_rvalid,
             rdata, mem_en, mem_we, mem_addr, mem_din, x_wait
   );

   modport master (
      output d_req, d_we, d_addr, d_wdata, f_req, f_addr,
             x_req, x_we, x_addr, x_wdata, mem_dout,
      input  d_gnt, d_rvalid, f_gnt, f_rvalid, x_gnt, x_rvalid,
             rdata, mem_en, mem_we, mem_addr, mem_din, x_wait
   );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Fixed-priority (D > F > X) arbiter for the single data-memory BRAM port,
// with a starvation guard that promotes X after STARVE_LIMIT denied cycles.
module dmem_port_arbiter #(
   parameter int ADDR_W       = 9,
   parameter int DATA_W       = 16,
   parameter int STARVE_LIMIT = 4
) (
   input logic       clk,
   input logic       rst_n,
   dmem_port_if.slave bus
);
   typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_D, OWN_F, OWN_X} owner_e;

   owner_e            owner_q, owner_d;
   logic [3:0]        wait_q;
   logic              promote;
   logic              d_win, f_win, x_win, we_sel;
   logic [ADDR_W-1:0] addr_sel;
   logic [DATA_W-1:0] din_sel;

   // Grants are gated by rst_n so the BRAM sees nothing while reset is held.
   always_comb begin
      d_win    = 1'b0;
      f_win    = 1'b0;
      x_win    = 1'b0;
      we_sel   = 1'b0;
      addr_sel = '0;
      din_sel  = '0;
      owner_d  = OWN_NONE;
      promote  = bus.x_req && (wait_q >= 4'(STARVE_LIMIT));
      if (rst_n) begin
         if (promote)        x_win = 1'b1;
         else if (bus.d_req) d_win = 1'b1;
         else if (bus.f_req) f_win = 1'b1;
         else if (bus.x_req) x_win = 1'b1;
      end
      if (d_win) begin
         we_sel   = bus.d_we;
         addr_sel = bus.d_addr;
         din_sel  = bus.d_wdata;
         if (!bus.d_we) owner_d = OWN_D;
      end else if (f_win) begin
         addr_sel = bus.f_addr;
         owner_d  = OWN_F;
      end else if (x_win) begin
         we_sel   = bus.x_we;
         addr_sel = bus.x_addr;
         din_sel  = bus.x_wdata;
         if (!bus.x_we) owner_d = OWN_X;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) owner_q <= OWN_NONE;
      else        owner_q <= owner_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                        wait_q <= 4'd0;
      else if (!bus.x_req || x_win)      wait_q <= 4'd0;
      else if (wait_q < 4'(STARVE_LIMIT)) wait_q <= wait_q + 4'd1;
   end

   assign bus.d_gnt    = d_win;
   assign bus.f_gnt    = f_win;
   assign bus.x_gnt    = x_win;
   assign bus.mem_en   = d_win | f_win | x_win;
   assign bus.mem_we   = we_sel;
   assign bus.mem_addr = addr_sel;
   assign bus.mem_din  = din_sel;
   assign bus.d_rvalid = (owner_q == OWN_D);
   assign bus.f_rvalid = (owner_q == OWN_F);
   assign bus.x_rvalid = (owner_q == OWN_X);
   assign bus.rdata    = bus.mem_dout;
   assign bus.x_wait   = wait_q;
endmodule
